neuron_mem_write_arbiter: RTL and testbench
===========================================

Name: neuron_mem_write_arbiter

Overview:
Round-robin write scheduler that shares the single write port of the 32x12 neuron memory among N_REQ independent writers. Each writer uses a req/grant handshake. The block drives one registered write per cycle to the memory and never issues a write when no request is granted. It sits between the neuron update units and the neuron memory; the memory read ports are untouched.

Parameters:
N_REQ, 20, number of writers
ADDR_W, 5, memory address width (32 words)
DATA_W, 12, memory word width
CNT_W, 16, width of the saturating write counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
arb_en  in  1  arbitration enable; 0 freezes scheduling
req  in  N_REQ  per-writer request, level, held until granted
req_addr  in  N_REQ*ADDR_W  packed addresses, writer i at [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  packed data, writer i at [i*DATA_W +: DATA_W]
grant  out  N_REQ  one-hot combinational grant; writer's word captured at this clock edge
mem_we  out  1  registered write enable to neuron memory
mem_waddr  out  ADDR_W  registered write address
mem_wdata  out  DATA_W  registered write data
wr_count  out  CNT_W  number of writes issued, saturating
busy  out  1  high when req is nonzero or mem_we is high

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: mem_we=0, mem_waddr=0, mem_wdata=0, wr_count=0, round-robin pointer ptr=0. grant=0 whenever rst_n=0.
- Arbitration (combinational):
  - If arb_en=1 and req!=0, grant the first asserted index searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - Otherwise grant=0.
  - grant is always zero or one-hot.
- Capture on the rising edge where grant[i]=1:
  - mem_we<=1, mem_waddr<=addr_i, mem_wdata<=data_i.
  - ptr<=(i+1) mod N_REQ; i=N_REQ-1 wraps to 0.
  - wr_count<=wr_count+1, saturating at 2^CNT_W-1 (holds at 0xFFFF).
- On an edge with no grant: mem_we<=0, and mem_waddr/mem_wdata hold their values. No write is ever issued without a grant.
- Latency: req high at edge k → grant during cycle k-1..k → mem_we high for cycle k..k+1 → memory updated at edge k+1.
- Throughput: one write per cycle. A writer holding req continuously is re-granted only after every other active writer has been served once.
- Handshake: the writer samples grant at the edge and must deassert req (or present new addr/data) in the following cycle. req, addr and data must be stable while req=1 and ungranted.
- Same-address requests from different writers are serialised in grant order; the last granted writer's data remains in memory.
- arb_en=0: grant=0, ptr holds, mem_we drops to 0 after the next edge. Pending requests persist and resume in RR order when arb_en returns to 1.
- Reset mid-operation: an in-flight registered write is dropped (mem_we forced 0 immediately). ptr returns to 0 and the counter clears.
- busy is combinational: busy = |req | mem_we.

Decomposition:
- Shared package neuron_mem_pkg holds:
  - ADDR_W=5, DATA_W=12, MEM_DEPTH=32, N_WRITERS=20
  - a typedef for neuron word (logic [11:0]) and neuron address (logic [4:0]).
- One sub-module, rr_pick: a parameterised N-bit round-robin priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and binary index.
  - Purely combinational, reusable by the read-side scheduler.

Test Plan:
- Reset then idle 10 cycles with req=0 → mem_we stays 0, wr_count=0, grant=0 every cycle.
- req[3]=1 alone with addr=5'd7, data=12'hABC → grant[3] for exactly one cycle; next cycle mem_we=1, mem_waddr=7, mem_wdata=0xABC; ptr becomes 4; wr_count=1.
- req[0], req[5], req[19] held high from ptr=0 → grant order 0,5,19,0,5,19 on consecutive cycles; mem_we high continuously; wr_count increments by 1 per cycle.
- ptr=19 with req[19]=1 and req[2]=1 → grant 19 first, then wrap to 2; ptr goes 19→0→3.
- Writers 4 and 9 both target addr 5'd12 with data 0x111 and 0x222 from ptr=5 → 9 granted first, then 4; the final memory word at 12 is 0x111.
- Abort and freeze: assert rst_n=0 mid-burst, with mem_we=1 → mem_we=0 and wr_count=0 immediately. Separately, drop arb_en for 3 cycles with requests pending → no grants and ptr unchanged; on re-enable, arbitration resumes from the saved ptr.

Source files
------------

// File: rtl/neuron_mem_pkg.sv
// rtl/neuron_mem_pkg.sv - shared geometry and types for the 32x12 neuron memory
package neuron_mem_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 12;
  localparam int MEM_DEPTH = 32;
  localparam int N_WRITERS = 20;

  typedef logic [DATA_W-1:0] neuronWord_t;
  typedef logic [ADDR_W-1:0] neuronAddr_t;

endpackage

// File: rtl/neuron_mem_write_arbiter_rr_pick.sv
// rtl/neuron_mem_write_arbiter_rr_pick.sv - combinational round-robin picker, first request at or after ptr
module rr_pick #(
  parameter int N  = 20,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic          found;
    int            j;
    logic [PW-1:0] jIdx;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jIdx  = '0;
    for (int k = 0; k < N; k++) begin
      j    = (int'(ptr) + k) % N;
      jIdx = PW'(j);
      if (!found && req[jIdx]) begin
        found       = 1'b1;
        grant[jIdx] = 1'b1;
        idx         = jIdx;
      end
    end
  end

endmodule

// File: rtl/neuron_mem_write_arbiter.sv
// rtl/neuron_mem_write_arbiter.sv - round-robin scheduler for the neuron memory write port
module neuron_mem_write_arbiter
  import neuron_mem_pkg::*;
#(
  parameter int N_REQ  = neuron_mem_pkg::N_WRITERS,
  parameter int ADDR_W = neuron_mem_pkg::ADDR_W,
  parameter int DATA_W = neuron_mem_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_waddr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [CNT_W-1:0]          wr_count,
  output logic                      busy
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]  ptr;
  logic [N_REQ-1:0]  pickGrant;
  logic [PTR_W-1:0]  pickIdx;
  logic [ADDR_W-1:0] addrArr [N_REQ];
  logic [DATA_W-1:0] dataArr [N_REQ];
  logic              anyGrant;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addrArr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign dataArr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(.N(N_REQ), .PW(PTR_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pickGrant),
    .idx   (pickIdx)
  );

  // Grant is masked by reset so no writer believes it was served while the port is held in reset.
  assign grant    = (rst_n && arb_en) ? pickGrant : '0;
  assign anyGrant = |grant;
  assign busy     = (|req) | mem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      wr_count  <= '0;
      ptr       <= '0;
    end else if (anyGrant) begin
      mem_we    <= 1'b1;
      mem_waddr <= addrArr[pickIdx];
      mem_wdata <= dataArr[pickIdx];
      ptr       <= (pickIdx == PTR_W'(N_REQ-1)) ? '0 : pickIdx + 1'b1;
      if (wr_count != '1) begin
        wr_count <= wr_count + 1'b1;
      end
    end else begin
      mem_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_mem_write_arbiter.sv
// tb/tb_neuron_mem_write_arbiter.sv - directed self-checking bench for neuron_mem_write_arbiter
module tb_neuron_mem_write_arbiter;

  localparam int N  = 20;
  localparam int AW = 5;
  localparam int DW = 12;
  localparam int CW = 16;

  logic              clk;
  logic              rst_n;
  logic              arb_en;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      grant;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;
  logic [CW-1:0]     wr_count;
  logic              busy;

  logic [DW-1:0]     tbMem [32];
  int                nCompared;
  int                nMismatch;
  int                order [6];

  neuron_mem_write_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .grant     (grant),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .wr_count  (wr_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) tbMem[mem_waddr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setW(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Checks the combinational grant mid-cycle, then returns just after the next rising edge.
  task automatic cycleGrant(input string tag, input int idx);
    logic [31:0] expG;
    expG = (idx < 0) ? 32'd0 : (32'd1 << idx);
    @(negedge clk);
    #1;
    chk(tag, 32'(grant), expG);
    @(posedge clk);
    #1;
  endtask

  initial begin
    nCompared = 0;
    nMismatch = 0;
    rst_n    = 1'b0;
    arb_en   = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    order    = '{0, 5, 19, 0, 5, 19};

    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_count", 32'(wr_count), 0);
    chk("rst_addr", 32'(mem_waddr), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      cycleGrant("idle_grant", -1);
      chk("idle_we", 32'(mem_we), 0);
      chk("idle_count", 32'(wr_count), 0);
    end

    // single writer 3
    setW(3, 5'd7, 12'hABC);
    req[3] = 1'b1;
    cycleGrant("single_grant", 3);
    req[3] = 1'b0;
    chk("single_we", 32'(mem_we), 1);
    chk("single_addr", 32'(mem_waddr), 7);
    chk("single_data", 32'(mem_wdata), 32'hABC);
    chk("single_ptr", 32'(dut.ptr), 4);
    chk("single_count", 32'(wr_count), 1);
    cycleGrant("single_after", -1);
    chk("single_we_drop", 32'(mem_we), 0);
    chk("single_addr_hold", 32'(mem_waddr), 7);

    // move ptr to 0 via writer 19
    setW(19, 5'd19, 12'h119);
    req[19] = 1'b1;
    cycleGrant("to0_grant", 19);
    req[19] = 1'b0;
    chk("to0_ptr", 32'(dut.ptr), 0);

    // three held writers rotate 0,5,19
    setW(0, 5'd0, 12'h100);
    setW(5, 5'd5, 12'h105);
    req[0] = 1'b1; req[5] = 1'b1; req[19] = 1'b1;
    for (int s = 0; s < 6; s++) begin
      cycleGrant("rr_grant", order[s]);
      chk("rr_we", 32'(mem_we), 1);
      chk("rr_addr", 32'(mem_waddr), 32'(order[s]));
      chk("rr_count", 32'(wr_count), 32'(3 + s));
    end
    req = '0;
    chk("rr_ptr", 32'(dut.ptr), 0);

    // ptr to 19 via writer 18, then wrap 19 -> 2
    setW(18, 5'd18, 12'h118);
    req[18] = 1'b1;
    cycleGrant("to19_grant", 18);
    req[18] = 1'b0;
    chk("to19_ptr", 32'(dut.ptr), 19);
    req[19] = 1'b1; req[2] = 1'b1;
    setW(2, 5'd2, 12'h102);
    cycleGrant("wrap_g19", 19);
    req[19] = 1'b0;
    chk("wrap_ptr0", 32'(dut.ptr), 0);
    cycleGrant("wrap_g2", 2);
    req[2] = 1'b0;
    chk("wrap_ptr3", 32'(dut.ptr), 3);
    chk("wrap_count", 32'(wr_count), 11);

    // ptr to 5 via writer 4, then same-address race 9 then 4
    setW(4, 5'd1, 12'h044);
    req[4] = 1'b1;
    cycleGrant("to5_grant", 4);
    chk("to5_ptr", 32'(dut.ptr), 5);
    setW(4, 5'd12, 12'h111);
    setW(9, 5'd12, 12'h222);
    req[9] = 1'b1;
    cycleGrant("same_g9", 9);
    req[9] = 1'b0;
    chk("same_data9", 32'(mem_wdata), 32'h222);
    cycleGrant("same_g4", 4);
    req[4] = 1'b0;
    chk("same_mem_222", 32'(tbMem[12]), 32'h222);
    chk("same_data4", 32'(mem_wdata), 32'h111);
    chk("same_ptr", 32'(dut.ptr), 5);

    // freeze for 3 cycles with writers 2 and 7 pending
    arb_en = 1'b0;
    req[2] = 1'b1; req[7] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycleGrant("frz_grant", -1);
      chk("frz_we", 32'(mem_we), 0);
      chk("frz_ptr", 32'(dut.ptr), 5);
      chk("frz_busy", 32'(busy), 1);
    end
    chk("same_mem_final", 32'(tbMem[12]), 32'h111);
    arb_en = 1'b1;
    setW(7, 5'd7, 12'h107);
    cycleGrant("resume_g7", 7);
    req[7] = 1'b0;
    chk("resume_ptr8", 32'(dut.ptr), 8);
    cycleGrant("resume_g2", 2);
    req[2] = 1'b0;
    chk("resume_ptr3", 32'(dut.ptr), 3);
    chk("resume_count", 32'(wr_count), 16);

    // asynchronous reset with a write in flight
    req[0] = 1'b1; req[1] = 1'b1;
    cycleGrant("abort_g0", 0);
    chk("abort_we_pre", 32'(mem_we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_count", 32'(wr_count), 0);
    chk("abort_grant", 32'(grant), 0);
    chk("abort_ptr", 32'(dut.ptr), 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // saturation of the write counter
    req[0] = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_count", 32'(wr_count), 32'hFFFF);
    chk("sat_we", 32'(mem_we), 1);
    req = '0;
    @(posedge clk);
    #1;
    chk("sat_hold", 32'(wr_count), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
